// File: rtl/cr_huf_comp_sym_histogram_pkg.sv
// Shared types for the Huffman compressor symbol histogram: pipeline EOB marker,
// histogram FSM states and the per-lane symbol record.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 4
`endif

package cr_huf_compPKG;

  typedef enum logic [1:0] {
    MIDDLE    = 2'd0,
    PASS1_EOB = 2'd1,
    PASS2_EOB = 2'd2,
    FINAL_EOB = 2'd3
  } e_pipe_eob;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } hc_hist_state_e;

  localparam int unsigned HC_DAT_WIDTH = 10;
  localparam int unsigned HC_CNT_WIDTH = 3;

  typedef struct packed {
    logic [HC_DAT_WIDTH-1:0] sym;
    logic [HC_CNT_WIDTH-1:0] cnt;
    logic                    vld;
  } hc_lane_t;

  function automatic logic is_eob(e_pipe_eob e);
    return e != MIDDLE;
  endfunction

endpackage

// File: rtl/cr_huf_comp_hist_merge.sv
// Combinational per-beat lane merge: sums counts of lanes sharing a symbol, flags the
// lowest-index lane of each symbol as the writer, and finds the beat's min/max symbol.
module cr_huf_comp_hist_merge #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned DAT_WIDTH = 10,
  parameter int unsigned CNT_WIDTH = 3,
  parameter int unsigned SUM_WIDTH = 6
) (
  input  logic [NUM_LANES*DAT_WIDTH-1:0] sym,
  input  logic [NUM_LANES*CNT_WIDTH-1:0] cnt,
  input  logic [NUM_LANES-1:0]           eff,
  output logic [NUM_LANES-1:0]           first,
  output logic [NUM_LANES*SUM_WIDTH-1:0] sum,
  output logic                           any,
  output logic [DAT_WIDTH-1:0]           min_sym,
  output logic [DAT_WIDTH-1:0]           max_sym
);

  logic [DAT_WIDTH-1:0] sym_a [NUM_LANES];
  logic [CNT_WIDTH-1:0] cnt_a [NUM_LANES];
  logic [SUM_WIDTH-1:0] sum_a [NUM_LANES];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign sym_a[g] = sym[g*DAT_WIDTH +: DAT_WIDTH];
    assign cnt_a[g] = cnt[g*CNT_WIDTH +: CNT_WIDTH];
    assign sum[g*SUM_WIDTH +: SUM_WIDTH] = sum_a[g];
  end

  assign any = |eff;

  always_comb begin
    first   = '0;
    min_sym = '1;
    max_sym = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      sum_a[i] = '0;
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      first[i] = eff[i];
      for (int j = 0; j < NUM_LANES; j++) begin
        if (eff[j] && (sym_a[j] == sym_a[i])) begin
          sum_a[i] = sum_a[i] + SUM_WIDTH'(cnt_a[j]);
          // An earlier lane with the same symbol owns the write.
          if (j < i) first[i] = 1'b0;
        end
      end
      if (eff[i]) begin
        if (sym_a[i] < min_sym) min_sym = sym_a[i];
        if (sym_a[i] > max_sym) max_sym = sym_a[i];
      end
    end
  end

endmodule

// File: rtl/cr_huf_comp_sym_histogram.sv
// Symbol-frequency histogram for the Huffman front end: input register stage, then an
// accumulate stage with saturating counts; the finished block is offered via out_vld/out_ready.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 4
`endif

module cr_huf_comp_sym_histogram
  import cr_huf_compPKG::*;
#(
  parameter int unsigned NUM_LANES        = 4,
  parameter int unsigned DAT_WIDTH        = 10,
  parameter int unsigned CNT_WIDTH        = 3,
  parameter int unsigned SYM_FREQ_WIDTH   = 15,
  parameter int unsigned CNTRL_WIDTH      = 1,
  parameter int unsigned MAX_NUM_SYM_USED = 576
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [NUM_LANES-1:0]                       in_vld,
  input  logic [NUM_LANES*DAT_WIDTH-1:0]             in_sym,
  input  logic [NUM_LANES*CNT_WIDTH-1:0]             in_cnt,
  input  logic [CNTRL_WIDTH-1:0]                     in_meta,
  input  logic [`CREOLE_HC_SEQID_WIDTH-1:0]          in_seq_id,
  input  e_pipe_eob                                  in_eob,
  output logic                                       in_rdy,
  output logic                                       out_vld,
  input  logic                                       out_ready,
  output logic [MAX_NUM_SYM_USED*SYM_FREQ_WIDTH-1:0] freq,
  output logic [DAT_WIDTH-1:0]                       sym_lo,
  output logic [DAT_WIDTH-1:0]                       sym_hi,
  output logic [$clog2(MAX_NUM_SYM_USED+1)-1:0]      sym_used,
  output logic [CNTRL_WIDTH-1:0]                     meta,
  output logic [`CREOLE_HC_SEQID_WIDTH-1:0]          seq_id,
  output e_pipe_eob                                  eob,
  output logic                                       sat_err,
  output logic                                       oor_err
);

  localparam int unsigned SUM_WIDTH  = CNT_WIDTH + $clog2(NUM_LANES) + 1;
  localparam int unsigned ACC_WIDTH  = SYM_FREQ_WIDTH + SUM_WIDTH;
  localparam int unsigned USED_WIDTH = $clog2(MAX_NUM_SYM_USED + 1);
  localparam int unsigned IDX_WIDTH  = $clog2(MAX_NUM_SYM_USED);
  localparam int unsigned SEQ_WIDTH  = `CREOLE_HC_SEQID_WIDTH;
  localparam logic [SYM_FREQ_WIDTH-1:0] FREQ_MAX = {SYM_FREQ_WIDTH{1'b1}};

  // Register stage R
  logic                          r_vld_q;
  logic [NUM_LANES-1:0]          r_lane_vld_q;
  logic [NUM_LANES*DAT_WIDTH-1:0] r_sym_q;
  logic [NUM_LANES*CNT_WIDTH-1:0] r_cnt_q;
  logic [CNTRL_WIDTH-1:0]        r_meta_q;
  logic [SEQ_WIDTH-1:0]          r_seq_q;
  e_pipe_eob                     r_eob_q;

  // Accumulate stage A and control
  hc_hist_state_e              state_q, state_d;
  logic                        pend_q, pend_d;
  e_pipe_eob                   eob_q, eob_d;
  logic [CNTRL_WIDTH-1:0]      meta_q, meta_d;
  logic [SEQ_WIDTH-1:0]        seq_q, seq_d;
  logic [SYM_FREQ_WIDTH-1:0]   freq_q [MAX_NUM_SYM_USED];
  logic [SYM_FREQ_WIDTH-1:0]   freq_d [MAX_NUM_SYM_USED];
  logic [USED_WIDTH-1:0]       used_q, used_d;
  logic [DAT_WIDTH-1:0]        lo_q, lo_d, hi_q, hi_d;
  logic                        sat_q, sat_d, oor_q, oor_d;

  logic accept, hs, done_entry;
  logic [DAT_WIDTH-1:0]        r_sym_a [NUM_LANES];
  logic [CNT_WIDTH-1:0]        r_cnt_a [NUM_LANES];
  logic [SUM_WIDTH-1:0]        m_sum_a [NUM_LANES];
  logic [NUM_LANES-1:0]        eff, oor_lane, m_first;
  logic [NUM_LANES*SUM_WIDTH-1:0] m_sum;
  logic                        m_any;
  logic [DAT_WIDTH-1:0]        m_min, m_max;
  logic [IDX_WIDTH-1:0]        idx;
  logic [SYM_FREQ_WIDTH-1:0]   old;
  logic [ACC_WIDTH-1:0]        acc;

  assign accept     = (|in_vld) && in_rdy;
  assign hs         = (state_q == DONE) && out_ready;
  assign done_entry = (state_q == ACC) && r_vld_q && is_eob(r_eob_q);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign r_sym_a[g]  = r_sym_q[g*DAT_WIDTH +: DAT_WIDTH];
    assign r_cnt_a[g]  = r_cnt_q[g*CNT_WIDTH +: CNT_WIDTH];
    assign m_sum_a[g]  = m_sum[g*SUM_WIDTH +: SUM_WIDTH];
    assign eff[g]      = r_lane_vld_q[g] && (r_cnt_a[g] != '0) &&
                         (32'(r_sym_a[g]) < MAX_NUM_SYM_USED);
    assign oor_lane[g] = r_lane_vld_q[g] && (r_cnt_a[g] != '0) &&
                         (32'(r_sym_a[g]) >= MAX_NUM_SYM_USED);
  end

  cr_huf_comp_hist_merge #(
    .NUM_LANES (NUM_LANES),
    .DAT_WIDTH (DAT_WIDTH),
    .CNT_WIDTH (CNT_WIDTH),
    .SUM_WIDTH (SUM_WIDTH)
  ) u_merge (
    .sym     (r_sym_q),
    .cnt     (r_cnt_q),
    .eff     (eff),
    .first   (m_first),
    .sum     (m_sum),
    .any     (m_any),
    .min_sym (m_min),
    .max_sym (m_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_q      <= 1'b0;
      r_lane_vld_q <= '0;
      r_sym_q      <= '0;
      r_cnt_q      <= '0;
      r_meta_q     <= '0;
      r_seq_q      <= '0;
      r_eob_q      <= MIDDLE;
    end else begin
      r_vld_q <= accept;
      if (accept) begin
        r_lane_vld_q <= in_vld;
        r_sym_q      <= in_sym;
        r_cnt_q      <= in_cnt;
        r_meta_q     <= in_meta;
        r_seq_q      <= in_seq_id;
        r_eob_q      <= in_eob;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    eob_d   = eob_q;
    meta_d  = meta_q;
    seq_d   = seq_q;
    if (accept && is_eob(in_eob)) pend_d = 1'b1;
    if (done_entry) begin
      state_d = DONE;
      pend_d  = 1'b0;
      eob_d   = r_eob_q;
      meta_d  = r_meta_q;
      seq_d   = r_seq_q;
    end
    if (hs) begin
      state_d = ACC;
      eob_d   = MIDDLE;
    end
  end

  always_comb begin
    freq_d = freq_q;
    used_d = used_q;
    lo_d   = lo_q;
    hi_d   = hi_q;
    sat_d  = sat_q;
    oor_d  = oor_q;
    idx    = '0;
    old    = '0;
    acc    = '0;
    if (hs) begin
      for (int k = 0; k < MAX_NUM_SYM_USED; k++) freq_d[k] = '0;
      used_d = '0;
      lo_d   = '0;
      hi_d   = '0;
      sat_d  = 1'b0;
      oor_d  = 1'b0;
    end else if (r_vld_q) begin
      if (|oor_lane) oor_d = 1'b1;
      // Merged lanes carry distinct symbols, so per-lane writes never collide.
      for (int i = 0; i < NUM_LANES; i++) begin
        if (m_first[i]) begin
          idx = r_sym_a[i][IDX_WIDTH-1:0];
          old = freq_q[idx];
          acc = ACC_WIDTH'(old) + ACC_WIDTH'(m_sum_a[i]);
          if (acc > ACC_WIDTH'(FREQ_MAX)) begin
            freq_d[idx] = FREQ_MAX;
            sat_d       = 1'b1;
          end else begin
            freq_d[idx] = acc[SYM_FREQ_WIDTH-1:0];
          end
          if (old == '0) used_d = used_d + USED_WIDTH'(1);
        end
      end
      // A nonzero used count doubles as "some symbol already seen".
      if (m_any) begin
        lo_d = ((used_q != '0) && (lo_q < m_min)) ? lo_q : m_min;
        hi_d = ((used_q != '0) && (hi_q > m_max)) ? hi_q : m_max;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      pend_q  <= 1'b0;
      eob_q   <= MIDDLE;
      meta_q  <= '0;
      seq_q   <= '0;
      used_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      sat_q   <= 1'b0;
      oor_q   <= 1'b0;
      for (int k = 0; k < MAX_NUM_SYM_USED; k++) freq_q[k] <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      eob_q   <= eob_d;
      meta_q  <= meta_d;
      seq_q   <= seq_d;
      used_q  <= used_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      sat_q   <= sat_d;
      oor_q   <= oor_d;
      freq_q  <= freq_d;
    end
  end

  for (genvar k = 0; k < MAX_NUM_SYM_USED; k++) begin : g_freq
    assign freq[k*SYM_FREQ_WIDTH +: SYM_FREQ_WIDTH] = freq_q[k];
  end

  assign in_rdy   = (state_q == ACC) && !pend_q;
  assign out_vld  = (state_q == DONE);
  assign sym_lo   = lo_q;
  assign sym_hi   = hi_q;
  assign sym_used = used_q;
  assign meta     = meta_q;
  assign seq_id   = seq_q;
  assign eob      = eob_q;
  assign sat_err  = sat_q;
  assign oor_err  = oor_q;

endmodule

// File: doc/cr_huf_comp_sym_histogram.md
# cr_huf_comp_sym_histogram

Parametrised symbol-frequency accumulator for the Huffman compressor front end. It accepts NUM_LANES (symbol, count) pairs per cycle from the symbol counter stage and accumulates a per-symbol frequency histogram over one block. At end-of-block it presents the histogram and block statistics to the tree builder with a valid/ready handshake. Compared with the fixed 4-lane counter, it adds:
- merging of same-symbol lanes within a beat;
- saturating counts with a sticky flag;
- a distinct-symbol count;
- out-of-range detection.

## Interface
Parameters:
- NUM_LANES, 4, symbols per input beat (1..8)
- DAT_WIDTH, 10, symbol width
- CNT_WIDTH, 3, per-lane count width
- SYM_FREQ_WIDTH, 15, histogram entry width
- CNTRL_WIDTH, 1, meta width
- MAX_NUM_SYM_USED, 576, histogram depth

Ports:
- clk  in  1  clock; the block uses one clock
- rst_n  in  1  reset, asynchronous, active-low
- in_vld  in  NUM_LANES  per-lane valid
- in_sym  in  NUM_LANES×DAT_WIDTH  packed symbols, lane 0 in the LSBs
- in_cnt  in  NUM_LANES×CNT_WIDTH  packed counts
- in_meta  in  CNTRL_WIDTH  block meta
- in_seq_id  in  `CREOLE_HC_SEQID_WIDTH  sequence id
- in_eob  in  e_pipe_eob  end-of-block marker; MIDDLE means not the last beat
- in_rdy  out  1  beat accepted when |in_vld && in_rdy
- out_vld  out  1  histogram complete
- out_ready  in  1  consumer takes the histogram
- freq  out  MAX_NUM_SYM_USED×SYM_FREQ_WIDTH  histogram
- sym_lo, sym_hi  out  DAT_WIDTH  lowest and highest symbol with nonzero count
- sym_used  out  $clog2(MAX_NUM_SYM_USED+1)  number of distinct symbols with nonzero frequency
- meta, seq_id, eob  out  captured from the final beat
- sat_err  out  1  sticky: some entry saturated
- oor_err  out  1  sticky: some symbol was ≥ MAX_NUM_SYM_USED

## Operation
- States: ACC (accumulating) and DONE (histogram presented).
- in_rdy = (state==ACC) && !eob_pending. eob_pending is a register:
  - set when a non-MIDDLE beat is accepted;
  - cleared on entry to DONE.
- Lane gating: lane i is effective when in_vld[i], in_cnt[i]!=0 and in_sym[i]<MAX_NUM_SYM_USED.
- Out-of-range: a valid lane with nonzero count and in_sym ≥ MAX_NUM_SYM_USED is dropped and sets oor_err.
- Lane merge: duplicate symbols in one beat are summed.
  - Only the lowest-index effective lane carrying a given symbol writes.
  - The value written is the old entry plus the sum of the counts of all effective lanes with that symbol.
- Saturating add: the result is clamped to 2^SYM_FREQ_WIDTH−1. Any clamp sets sat_err.
- sym_used increments by the number of distinct effective symbols whose old entry was 0.
- sym_lo/sym_hi: running min/max over effective symbols. They stay 0 while no symbol has been seen.
- End of block: the beat with in_eob!=MIDDLE is applied like any other beat. Then the state goes to DONE and eob/meta/seq_id are latched from that beat.
- DONE: out_vld=1 and all outputs are held stable.
- Handshake: on out_vld && out_ready, all of the following are cleared to 0 and the state returns to ACC:
  - freq, sym_lo, sym_hi, sym_used, sat_err, oor_err;
  - eob is set to MIDDLE.
- An empty block (non-MIDDLE beat with no effective lane) still produces out_vld, with all statistics 0.

## Timing
- Input register stage R, then accumulate stage A.
- A beat accepted in cycle T is visible in freq, sym_lo, sym_hi and sym_used in cycle T+2.
- out_vld for an eob beat accepted in cycle T asserts in cycle T+2.
- in_rdy drops in cycle T+1 and returns one cycle after the out_ready handshake.
- out_vld may stay high indefinitely. out_ready asserted while out_vld=0 is ignored.
- Reset values: in_rdy=1, out_vld=0, and every other output 0 except eob=MIDDLE. State=ACC.
- Reset applied mid-block discards all accumulation.

## Structure
- Shared package (cr_huf_compPKG) holds:
  - e_pipe_eob;
  - the state enum hc_hist_state_e (ACC, DONE);
  - a lane struct {sym, cnt, vld}.
- One sub-module, cr_huf_comp_hist_merge. It is combinational and performs, per beat:
  - duplicate detection;
  - per-lane merged count;
  - first-occurrence flags;
  - per-beat min/max.
- The accumulate stage and handshake stay in the top module.
- The standard CLK_GATE cr_clk_gate instance is optional. It must be open whenever either stage holds a beat or out_vld is high.

## Test plan
- **Single-lane block:** beats (sym 5, cnt 3), (sym 5, cnt 2); the second carries in_eob!=MIDDLE. Required: out_vld two cycles after the eob beat, freq[5]=5, sym_lo=sym_hi=5, sym_used=1.
- **Lane collision:** one beat with all four lanes on sym 7 and counts 1,2,3,4. Required: freq[7]=10, sym_used=1.
- **Saturation:** SYM_FREQ_WIDTH=4; feed sym 0 with cnt 7 three times. Required: freq[0]=15, sat_err=1.
- **Out of range:** a lane with sym 600 and cnt 1. Required: oor_err=1, no freq change, sym_hi unaffected.
- **Backpressure:** hold out_ready=0 for 20 cycles after out_vld. Required:
  - outputs stable and in_rdy=0 throughout;
  - after the handshake, freq is all zero and in_rdy=1 one cycle later.
- **Empty block and mid-block reset:**
  - An eob-only beat gives out_vld with sym_used=0.
  - rst_n pulsed after 3 beats gives a clean histogram on the next block.
